// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the RAM slave front end.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_COLLECT, W_RAM, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_RAM, R_DATA} rd_state_t;

endpackage

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave that converts write/read transactions into single-cycle strobes
// on a word-addressed RAM with a 1-cycle registered read port.
module axi_lite_ram_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic                write_EN,
  output logic [31:0]         write_address,
  output logic [DATA_W-1:0]   write_data,
  output logic                read_EN,
  output logic [31:0]         read_address,
  input  logic [DATA_W-1:0]   read_data
);

  localparam int STRB_W = DATA_W / 8;

  // ---------------- write channel ----------------
  wr_state_t           wr_state, wr_next;
  logic                aw_held, w_held;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [ADDR_W-1:0]   aw_index;
  logic                aw_hs, w_hs, wr_ok;

  // Readies depend only on state and held flags, never on the valids.
  assign s_awready = !rst && (wr_state == W_COLLECT) && !aw_held;
  assign s_wready  = !rst && (wr_state == W_COLLECT) && !w_held;
  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;

  assign aw_index  = awaddr_q >> 2;
  assign wr_ok     = (aw_index < ADDR_W'(DEPTH)) && (&wstrb_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_COLLECT;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
      if (wr_state == W_RESP && s_bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // NOTE: payload registers carry no reset; they are only consumed once the
  // matching held flag (which is reset) says they were loaded.
  always_ff @(posedge clk) begin
    if (aw_hs) awaddr_q <= s_awaddr;
    if (w_hs) begin
      wdata_q <= s_wdata;
      wstrb_q <= s_wstrb;
    end
  end

  always_comb begin
    wr_next       = wr_state;
    s_bvalid      = 1'b0;
    s_bresp       = RESP_OKAY;
    write_EN      = 1'b0;
    write_address = '0;
    write_data    = '0;
    if (!rst) begin
      unique case (wr_state)
        W_COLLECT: begin
          // A handshake completing this edge counts as held for the transition.
          if ((aw_held || aw_hs) && (w_held || w_hs)) wr_next = W_RAM;
        end
        W_RAM: begin
          write_EN      = wr_ok;
          write_address = 32'(aw_index);
          write_data    = wdata_q;
          wr_next       = W_RESP;
        end
        W_RESP: begin
          s_bvalid = 1'b1;
          s_bresp  = wr_ok ? RESP_OKAY : RESP_SLVERR;
          if (s_bready) wr_next = W_COLLECT;
        end
        default: wr_next = W_COLLECT;
      endcase
    end
  end

  // ---------------- read channel ----------------
  rd_state_t         rd_state, rd_next;
  logic [ADDR_W-1:0] araddr_q;
  logic              ar_err_q;
  logic              ar_hs, ar_in_range;

  assign s_arready   = !rst && (rd_state == R_IDLE);
  assign ar_hs       = s_arvalid && s_arready;
  assign ar_in_range = (s_araddr >> 2) < ADDR_W'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst) rd_state <= R_IDLE;
    else     rd_state <= rd_next;
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      araddr_q <= s_araddr;
      ar_err_q <= !ar_in_range;
    end
  end

  always_comb begin
    rd_next      = rd_state;
    s_rvalid     = 1'b0;
    s_rresp      = RESP_OKAY;
    s_rdata      = '0;
    read_EN      = 1'b0;
    read_address = '0;
    if (!rst) begin
      unique case (rd_state)
        R_IDLE: begin
          if (ar_hs) rd_next = ar_in_range ? R_RAM : R_DATA;
        end
        R_RAM: begin
          read_EN      = 1'b1;
          read_address = 32'(araddr_q >> 2);
          rd_next      = R_DATA;
        end
        R_DATA: begin
          // RAM holds read_data until the next read_EN, which only we issue.
          s_rvalid = 1'b1;
          s_rresp  = ar_err_q ? RESP_SLVERR : RESP_OKAY;
          s_rdata  = ar_err_q ? '0 : read_data;
          if (s_rready) rd_next = R_IDLE;
        end
        default: rd_next = R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Self-checking bench: directed AXI4-Lite scenarios plus randomized traffic
// compared against an array-based memory model.
module tb_axi_lite_ram_slave;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid, s_awready;
  logic [DATA_W-1:0] s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid, s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid, s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid, s_arready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid, s_rready;
  logic              write_EN, read_EN;
  logic [31:0]       write_address, read_address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data = '0;

  always #5 clk = ~clk;

  axi_lite_ram_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .write_EN(write_EN), .write_address(write_address), .write_data(write_data),
    .read_EN(read_EN), .read_address(read_address), .read_data(read_data)
  );

  // Word RAM with registered read, mem[i] = 2*i at start.
  logic [DATA_W-1:0] mem [DEPTH];
  bit ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(2 * i);
      ram_loaded <= 1'b1;
    end else begin
      if (read_EN && read_address < DEPTH) read_data <= mem[read_address];
      if (write_EN && write_address < DEPTH) mem[write_address] <= write_data;
    end
  end

  int cyc = 0, wen_cnt = 0, ren_cnt = 0, last_wen_cyc = -1, last_ren_cyc = -2;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (write_EN) begin
      wen_cnt      <= wen_cnt + 1;
      last_wen_cyc <= cyc;
    end
    if (read_EN) begin
      ren_cnt      <= ren_cnt + 1;
      last_ren_cyc <= cyc;
    end
  end

  logic [DATA_W-1:0] model [DEPTH];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at a negedge after the B handshake.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_start, input int w_start, input int b_delay);
    bit ok, aw_done, w_done, aw_hs, w_hs;
    logic [1:0] exp_resp;
    int base_wen, n, lat;
    ok       = ((addr >> 2) < DEPTH) && (strb == 4'hF);
    exp_resp = ok ? OKAY : SLVERR;
    base_wen = wen_cnt;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    aw_done  = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      s_awvalid = !aw_done && (n >= aw_start);
      s_wvalid  = !w_done && (n >= w_start);
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      @(posedge clk);
      aw_done |= aw_hs;
      w_done  |= w_hs;
      n++;
      @(negedge clk);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (!(aw_done && w_done)) check("wr_accept_timeout", 0, 1);
    lat = 1;
    while (!s_bvalid && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    check("b_latency", lat, 2);
    for (int i = 0; i < b_delay; i++) begin
      check("bvalid_hold", s_bvalid, 1);
      check("bresp_hold", s_bresp, exp_resp);
      check("wr_blocked", {s_awready, s_wready}, 2'b00);
      @(posedge clk); @(negedge clk);
    end
    s_bready = 1'b1;
    check("bresp", s_bresp, exp_resp);
    @(posedge clk); @(negedge clk);
    s_bready = 1'b0;
    check("bvalid_drop", s_bvalid, 0);
    check("wen_pulses", wen_cnt - base_wen, ok ? 1 : 0);
    if (ok) model[addr >> 2] = data;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_delay);
    bit in_range;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int n, lat;
    in_range = (addr >> 2) < DEPTH;
    exp_data = in_range ? model[addr >> 2] : 32'h0;
    exp_resp = in_range ? OKAY : SLVERR;
    s_araddr = addr; s_arvalid = 1'b1; n = 0;
    while (!s_arready && n < 50) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (!s_arready) check("rd_accept_timeout", 0, 1);
    @(posedge clk); @(negedge clk);
    s_arvalid = 1'b0;
    lat = 1;
    while (!s_rvalid && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    check("r_latency", lat, in_range ? 2 : 1);
    for (int i = 0; i < r_delay; i++) begin
      check("rvalid_hold", s_rvalid, 1);
      check("rdata_hold", s_rdata, exp_data);
      check("rd_blocked", s_arready, 0);
      @(posedge clk); @(negedge clk);
    end
    s_rready = 1'b1;
    check("rdata", s_rdata, exp_data);
    check("rresp", s_rresp, exp_resp);
    @(posedge clk); @(negedge clk);
    s_rready = 1'b0;
    check("rvalid_drop", s_rvalid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base_wen, base_ren;
    for (int i = 0; i < DEPTH; i++) model[i] = DATA_W'(2 * i);
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, write_EN, read_EN, s_bresp, s_rresp}, 0);
    check("reset_rdata", s_rdata, 0);
    rst = 1'b0;
    #1;
    check("idle_readies", {s_awready, s_wready, s_arready}, 3'b111);
    @(negedge clk);

    axi_read(32'h14, 0);
    check("read_0x14_index", read_address, 0);
    axi_write(32'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(32'h40, 0);
    check("mem_0x40", mem[16], 32'hDEADBEEF);

    base_wen = wen_cnt;
    axi_write(32'h24, 32'h1111_2222, 4'hF, 3, 0, 0);
    axi_write(32'h28, 32'h3333_4444, 4'hF, 0, 3, 0);
    check("order_wen_total", wen_cnt - base_wen, 2);
    check("mem_w_first", mem[9], 32'h1111_2222);
    check("mem_aw_first", mem[10], 32'h3333_4444);

    axi_write(32'h80, 32'hBAD0BAD0, 4'hF, 0, 0, 0);
    axi_write(32'h0C, 32'hBAD1BAD1, 4'h3, 0, 0, 0);
    check("mem_unchanged_strb", mem[3], 32'h6);
    base_ren = ren_cnt;
    axi_read(32'h80, 0);
    check("oor_no_read_en", ren_cnt - base_ren, 0);

    axi_write(32'h30, 32'hCAFE0001, 4'hF, 0, 0, 5);
    axi_read(32'h30, 4);

    fork
      axi_write(32'h0C, 32'h55, 4'hF, 0, 0, 0);
      axi_read(32'h0C, 0);
    join
    check("same_cycle_strobes", last_wen_cyc, last_ren_cyc);
    axi_read(32'h0C, 0);

    // Reset while the write FSM is in W_RAM.
    base_wen = wen_cnt;
    s_awaddr = 32'h8; s_wdata = 32'h1234_5678; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_gates_wen", write_EN, 0);
    @(posedge clk); @(negedge clk);
    check("rst_mid_outputs", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, write_EN, read_EN}, 0);
    rst = 1'b0;
    #1;
    check("rst_idle_readies", {s_awready, s_wready, s_arready}, 3'b111);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check("rst_no_bvalid", s_bvalid, 0);
    end
    check("rst_no_wen", wen_cnt - base_wen, 0);
    check("rst_mem_kept", mem[2], 32'h4);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] addr, data;
      logic [3:0]  strb;
      addr = (32'($urandom_range(0, 39)) << 2) | 32'($urandom_range(0, 3));
      data = $urandom;
      strb = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 1) == 0)
        axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(addr, $urandom_range(0, 3));
    end
    for (int i = 0; i < DEPTH; i++) check("final_mem", mem[i], model[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
